// File: rtl/ram_output_ctrl.sv
// rtl/ram_output_ctrl.sv - RAM read-data output register and CPU wait generator
// Registers per-channel read data and drives wait_a_n from AXI address readiness.
module ram_output_ctrl #(
  parameter int DATA_W       = 8,
  parameter int CHANNELS     = 2,
  parameter int CAPTURE_MODE = 0,
  parameter int MIN_WAIT     = 1,
  parameter int TIMEOUT      = 1024,
  parameter int CNT_W        = 16
) (
  input  logic                       clk_peripheral_n,
  input  logic                       reset_n,
  input  logic [CHANNELS*DATA_W-1:0] data_i,
  input  logic [CHANNELS-1:0]        data_valid_i,
  output logic [CHANNELS*DATA_W-1:0] data_o,
  output logic [CHANNELS-1:0]        data_valid_o,
  input  logic                       aw_ready,
  input  logic                       ar_ready,
  output logic                       wait_a_n,
  input  logic                       clear_i,
  output logic                       timeout_o,
  output logic [CNT_W-1:0]           wait_cycles_o
);

  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_WAIT);
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam bit               TMO_EN  = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_READY   = 2'd0,
    S_WAIT    = 2'd1,
    S_TIMEOUT = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ready;

  assign ready = aw_ready & ar_ready;

  generate
    if (CAPTURE_MODE == 0) begin : g_free
      logic unused_valid;
      assign unused_valid = ^data_valid_i;

      always_ff @(posedge clk_peripheral_n) begin
        if (!reset_n) begin
          data_o       <= '0;
          data_valid_o <= '0;
        end else begin
          data_o       <= data_i;
          data_valid_o <= '1;
        end
      end
    end else begin : g_capture
      // Each channel loads on its own strobe; untouched channels hold.
      always_ff @(posedge clk_peripheral_n) begin
        if (!reset_n) begin
          data_o       <= '0;
          data_valid_o <= '0;
        end else begin
          data_valid_o <= data_valid_i;
          for (int c = 0; c < CHANNELS; c++) begin
            if (data_valid_i[c]) begin
              data_o[c*DATA_W +: DATA_W] <= data_i[c*DATA_W +: DATA_W];
            end
          end
        end
      end
    end
  endgenerate

  // The timeout set is written after the clear so a coincident set wins.
  always_ff @(posedge clk_peripheral_n) begin
    if (!reset_n) begin
      state         <= S_READY;
      wait_a_n      <= 1'b1;
      timeout_o     <= 1'b0;
      wait_cycles_o <= '0;
      cnt           <= '0;
    end else begin
      if (clear_i) begin
        timeout_o <= 1'b0;
      end
      case (state)
        S_READY: begin
          if (!ready) begin
            state    <= S_WAIT;
            wait_a_n <= 1'b0;
            cnt      <= CNT_ONE;
          end
        end
        S_WAIT: begin
          if (ready && (cnt >= MIN_CNT)) begin
            state         <= S_READY;
            wait_a_n      <= 1'b1;
            wait_cycles_o <= cnt;
          end else if (TMO_EN && (cnt == TMO_CNT)) begin
            state         <= S_TIMEOUT;
            wait_a_n      <= 1'b1;
            timeout_o     <= 1'b1;
            wait_cycles_o <= cnt;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_TIMEOUT: begin
          // CPU already released; hold off a new wait until the bus recovers.
          if (ready) begin
            state <= S_READY;
          end
        end
        default: begin
          state    <= S_READY;
          wait_a_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_output_ctrl.sv
// tb/tb_ram_output_ctrl.sv - randomized self-checking bench for ram_output_ctrl
module tb_ram_output_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] data_i;
  logic [1:0]  data_valid_i;
  logic        aw_ready, ar_ready, clear_i;

  logic [15:0] d0, d1;
  logic [1:0]  dv0, dv1;
  logic        w0, w1, to0, to1;
  logic [15:0] wc0;
  logic [3:0]  wc1;

  always #5 clk = ~clk;

  // Free-running data, MIN_WAIT=3, TIMEOUT=8.
  ram_output_ctrl #(.DATA_W(8), .CHANNELS(2), .CAPTURE_MODE(0), .MIN_WAIT(3),
                    .TIMEOUT(8), .CNT_W(16)) u_free (
    .clk_peripheral_n(clk), .reset_n(reset_n), .data_i(data_i),
    .data_valid_i(data_valid_i), .data_o(d0), .data_valid_o(dv0),
    .aw_ready(aw_ready), .ar_ready(ar_ready), .wait_a_n(w0),
    .clear_i(clear_i), .timeout_o(to0), .wait_cycles_o(wc0));

  // Captured data, MIN_WAIT=1, no timeout, narrow saturating counter.
  ram_output_ctrl #(.DATA_W(8), .CHANNELS(2), .CAPTURE_MODE(1), .MIN_WAIT(1),
                    .TIMEOUT(0), .CNT_W(4)) u_cap (
    .clk_peripheral_n(clk), .reset_n(reset_n), .data_i(data_i),
    .data_valid_i(data_valid_i), .data_o(d1), .data_valid_o(dv1),
    .aw_ready(aw_ready), .ar_ready(ar_ready), .wait_a_n(w1),
    .clear_i(clear_i), .timeout_o(to1), .wait_cycles_o(wc1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: 0 = idle, 1 = CPU held, 2 = released on a hung bus.
  int   p_min[2]  = '{3, 1};
  int   p_tmo[2]  = '{8, 0};
  int   p_cmax[2] = '{65535, 15};
  int   m_mode[2];
  int   m_low[2];
  int   e_wc[2];
  logic e_wn[2];
  logic e_to[2];
  logic [15:0] e_d0, e_d1;
  logic [1:0]  e_dv0, e_dv1;

  task automatic model_update();
    bit rdy, set;
    rdy = aw_ready && ar_ready;
    if (!reset_n) begin
      e_d0 = 0; e_d1 = 0; e_dv0 = 0; e_dv1 = 0;
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = 0; m_low[i] = 0; e_wc[i] = 0; e_wn[i] = 1'b1; e_to[i] = 1'b0;
      end
      return;
    end
    e_d0  = data_i;
    e_dv0 = 2'b11;
    e_dv1 = data_valid_i;
    if (data_valid_i[0]) e_d1[7:0]  = data_i[7:0];
    if (data_valid_i[1]) e_d1[15:8] = data_i[15:8];
    for (int i = 0; i < 2; i++) begin
      set = 0;
      if (m_mode[i] == 0) begin
        if (!rdy) begin m_mode[i] = 1; m_low[i] = 1; e_wn[i] = 1'b0; end
      end else if (m_mode[i] == 1) begin
        if (rdy && m_low[i] >= p_min[i]) begin
          m_mode[i] = 0; e_wn[i] = 1'b1; e_wc[i] = m_low[i];
        end else if (p_tmo[i] != 0 && m_low[i] == p_tmo[i]) begin
          m_mode[i] = 2; e_wn[i] = 1'b1; e_wc[i] = m_low[i]; set = 1;
        end else if (m_low[i] < p_cmax[i]) begin
          m_low[i]++;
        end
      end else if (rdy) begin
        m_mode[i] = 0;
      end
      if (set) e_to[i] = 1'b1;
      else if (clear_i) e_to[i] = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("free_data", d0, e_d0);
    check("free_valid", dv0, e_dv0);
    check("free_wait", w0, e_wn[0]);
    check("free_timeout", to0, e_to[0]);
    check("free_wait_cycles", wc0, e_wc[0]);
    check("cap_data", d1, e_d1);
    check("cap_valid", dv1, e_dv1);
    check("cap_wait", w1, e_wn[1]);
    check("cap_timeout", to1, e_to[1]);
    check("cap_wait_cycles", wc1, e_wc[1]);
  endtask

  // Called on a falling edge; applies inputs, advances one clock, checks.
  task automatic step(input logic rn, input logic [15:0] di, input logic [1:0] dv,
                      input logic aw, input logic ar, input logic clr);
    reset_n = rn; data_i = di; data_valid_i = dv;
    aw_ready = aw; ar_ready = ar; clear_i = clr;
    model_update();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int lows, lows1, burst;
    logic aw, ar;
    reset_n = 1'b0; data_i = 0; data_valid_i = 0;
    aw_ready = 0; ar_ready = 0; clear_i = 0;
    @(negedge clk);

    repeat (3) step(1'b0, 16'hA55A, 2'b11, 1'b0, 1'b0, 1'b0);
    check("rst_wait", w0, 1'b1);
    check("rst_data", d0, 16'h0000);
    check("rst_timeout", to0, 1'b0);
    check("rst_wait_cycles", wc0, 16'd0);

    step(1'b1, 16'h1234, 2'b00, 1'b1, 1'b1, 1'b0);
    check("free_1234", d0, 16'h1234);
    check("free_valid_11", dv0, 2'b11);

    step(1'b1, 16'hEF00, 2'b10, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'hBEEF, 2'b01, 1'b1, 1'b1, 1'b0);
    check("cap_efef", d1, 16'hEFEF);
    check("cap_pulse_01", dv1, 2'b01);
    step(1'b1, 16'h1122, 2'b10, 1'b1, 1'b1, 1'b0);
    check("cap_11ef", d1, 16'h11EF);
    check("cap_pulse_10", dv1, 2'b10);
    step(1'b1, 16'h3344, 2'b00, 1'b1, 1'b1, 1'b0);
    check("cap_hold", d1, 16'h11EF);

    lows = 0; lows1 = 0;
    step(1'b1, 16'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    lows += !w0; lows1 += !w1;
    repeat (6) begin
      step(1'b1, 16'h0, 2'b00, 1'b1, 1'b1, 1'b0);
      lows += !w0; lows1 += !w1;
    end
    check("glitch_low_min3", lows, 3);
    check("glitch_cycles", wc0, 16'd3);
    check("glitch_low_min1", lows1, 1);

    lows = 0;
    repeat (5) begin
      step(1'b1, 16'h0, 2'b00, 1'b0, 1'b1, 1'b0);
      lows += !w0;
    end
    repeat (5) begin
      step(1'b1, 16'h0, 2'b00, 1'b1, 1'b1, 1'b0);
      lows += !w0;
    end
    check("aw_low5", lows, 5);
    check("aw_cycles", wc0, 16'd5);

    lows = 0; lows1 = 0;
    repeat (20) begin
      step(1'b1, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0);
      lows += !w0; lows1 += !w1;
    end
    check("timeout_low", lows, 8);
    check("timeout_flag", to0, 1'b1);
    check("timeout_cycles", wc0, 16'd8);
    check("no_timeout_low", lows1, 20);
    step(1'b1, 16'h0, 2'b00, 1'b1, 1'b1, 1'b0);
    check("saturated_cycles", wc1, 4'd15);

    repeat (8) step(1'b1, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    check("set_beats_clear", to0, 1'b1);
    step(1'b1, 16'h0, 2'b00, 1'b1, 1'b1, 1'b1);
    check("clear_timeout", to0, 1'b0);

    repeat (4) step(1'b1, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    check("midwait_reset_wait", w0, 1'b1);
    check("midwait_reset_cycles", wc0, 16'd0);
    step(1'b1, 16'h0, 2'b00, 1'b1, 1'b1, 1'b0);

    burst = 0;
    repeat (3000) begin
      aw = 1'b1; ar = 1'b1;
      if (burst > 0) begin
        aw = 1'b0; burst--;
      end else if ($urandom_range(11) == 0) begin
        burst = $urandom_range(20, 1);
      end
      if ($urandom_range(14) == 0) ar = 1'b0;
      step($urandom_range(199) != 0, 16'($urandom), 2'($urandom), aw, ar,
           $urandom_range(19) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
